// File: rtl/extmem_arb_pkg.sv
// Shared types for the external memory arbiter: FSM states, requester IDs, grant bits.
// Also holds the data value returned to a requester whose transaction timed out.
package extmem_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  typedef enum logic [1:0] {ID_LD, ID_VID, ID_ROM} req_id_t;

  // Bit positions inside the one-hot grant vector.
  localparam int G_LD  = 0;
  localparam int G_VID = 1;
  localparam int G_ROM = 2;

  localparam logic [7:0] ABORT_DAT = 8'hFF;

endpackage

// File: rtl/extmem_prio.sv
// Combinational winner select, zero latency: loader > video > rom, except that a
// saturated video streak lets a pending rom request past video; losers simply stay pending.
module extmem_prio
  import extmem_arb_pkg::*;
(
  input  logic       ldreq,
  input  logic       vidreq,
  input  logic       romreq,
  input  logic       vidsat,
  output logic [2:0] grant
);

  always_comb begin
    grant = '0;
    if (ldreq)                 grant[G_LD]  = 1'b1;
    else if (romreq && vidsat) grant[G_ROM] = 1'b1;
    else if (vidreq)           grant[G_VID] = 1'b1;
    else if (romreq)           grant[G_ROM] = 1'b1;
  end

endmodule

// File: rtl/extmem_arb.sv
// Shares the external memory port between loader, video and NES rom; one transaction in flight.
// Latency: req at T -> extreq at T+1 -> ack one cycle after extack; stalls on extack up to TIMEOUT cycles.
module extmem_arb
  import extmem_arb_pkg::*;
#(
  parameter int AW      = 22,
  parameter int MAXVID  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ldaddr,
  input  logic [7:0]    ldwdata,
  input  logic          ldreq,
  output logic          ldack,
  input  logic [AW-1:0] vidaddr,
  input  logic          vidreq,
  output logic [7:0]    viddata,
  output logic          vidack,
  input  logic [AW-1:0] romaddr,
  input  logic          romreq,
  output logic [7:0]    romdata,
  output logic          romack,
  output logic [AW-1:0] extaddr,
  output logic [7:0]    extwdata,
  output logic          extwr,
  output logic          extreq,
  input  logic [7:0]    extrdata,
  input  logic          extack,
  output logic          err
);

  localparam int VCW = $clog2(MAXVID + 1);

  state_t         state;
  req_id_t        win;
  logic [VCW-1:0] vidcnt;
  logic [7:0]     tocnt;
  logic [2:0]     grant;
  logic           vidsat;
  logic           done;
  logic [7:0]     rdat;

  assign vidsat = (vidcnt >= VCW'(MAXVID));
  // A transaction ends on extack or when the timeout counter expires.
  assign done   = (state == ST_WAIT) && (extack || (tocnt == 8'(TIMEOUT)));
  assign rdat   = extack ? extrdata : ABORT_DAT;

  extmem_prio u_prio (
    .ldreq  (ldreq),
    .vidreq (vidreq),
    .romreq (romreq),
    .vidsat (vidsat),
    .grant  (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      win      <= ID_LD;
      ldack    <= 1'b0;
      vidack   <= 1'b0;
      romack   <= 1'b0;
      extreq   <= 1'b0;
      extwr    <= 1'b0;
      extaddr  <= '0;
      extwdata <= '0;
      viddata  <= '0;
      romdata  <= '0;
      vidcnt   <= '0;
      tocnt    <= '0;
      err      <= 1'b0;
    end else begin
      ldack  <= 1'b0;
      vidack <= 1'b0;
      romack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            state  <= ST_WAIT;
            extreq <= 1'b1;
            tocnt  <= '0;
            if (grant[G_LD]) begin
              win      <= ID_LD;
              extaddr  <= ldaddr;
              extwdata <= ldwdata;
              extwr    <= 1'b1;
            end else if (grant[G_VID]) begin
              win     <= ID_VID;
              extaddr <= vidaddr;
              extwr   <= 1'b0;
            end else begin
              win     <= ID_ROM;
              extaddr <= romaddr;
              extwr   <= 1'b0;
            end
            // Video streak only grows while rom is actually waiting; loader grants leave it alone.
            if (grant[G_VID] && romreq) begin
              if (!vidsat) vidcnt <= vidcnt + VCW'(1);
            end else if (grant[G_ROM] || !romreq) begin
              vidcnt <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (done) begin
            state  <= ST_ACK;
            extreq <= 1'b0;
            extwr  <= 1'b0;
            if (!extack) err <= 1'b1;
            case (win)
              ID_LD:   ldack <= 1'b1;
              ID_VID:  begin vidack <= 1'b1; viddata <= rdat; end
              ID_ROM:  begin romack <= 1'b1; romdata <= rdat; end
              default: ;
            endcase
          end else begin
            tocnt <= tocnt + 8'd1;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
